diffeq_controller: RTL and testbench

- Control FSM that drives the differential-equation solver datapath. It sequences nibble-serial operand loading (x, dx, a, u) and steps the datapath through four compute phases per loop iteration.
- It consumes the datapath's compute_done and continue_while, and terminates on loop exit, iteration limit or watchdog timeout.
- Sits between the top-level start/input handshake and the datapath's load_* and state[2:0] inputs.

---
 rtl/diffeq_controller.sv | 121 ++++++++++++
 tb/tb_diffeq_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/diffeq_controller.sv
// Control FSM for the differential-equation solver datapath: nibble-serial operand
// loading followed by four compute phases per loop iteration, with iteration and timeout guards.
module diffeq_controller #(
    parameter int MAX_ITER = 255,
    parameter int TIMEOUT  = 64,
    parameter int ITER_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic              compute_done,
    input  logic              continue_while,
    output logic              in_ready,
    output logic              load_x,
    output logic              load_dx,
    output logic              load_a,
    output logic              load_u,
    output logic [2:0]        state,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ITER_W-1:0] iter_count
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        READ      = 3'b001,
        COMPUTE_1 = 3'b010,
        COMPUTE_2 = 3'b011,
        COMPUTE_3 = 3'b100,
        COMPUTE_4 = 3'b101,
        DONE      = 3'b110
    } state_t;

    state_t             cur_state;
    state_t             next_state;
    logic [1:0]         idx;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   timer_next;
    logic [ITER_W-1:0]  iter_inc;
    logic               in_compute;
    logic               advance;
    logic               timed_out;
    logic               limit_hit;
    logic               accept_start;
    logic               accept_nibble;
    logic               loop_exit;

    // A timer of zero marks the first cycle of a phase, where a stale compute_done is masked.
    always_comb begin
        in_compute    = (cur_state == COMPUTE_1) || (cur_state == COMPUTE_2) ||
                        (cur_state == COMPUTE_3) || (cur_state == COMPUTE_4);
        advance       = in_compute && compute_done && (timer != '0);
        timed_out     = in_compute && !advance && ((int'(timer) + 1) >= TIMEOUT);
        iter_inc      = (iter_count == '1) ? iter_count : iter_count + 1'b1;
        limit_hit     = (MAX_ITER != 0) && (int'(iter_inc) == MAX_ITER);
        accept_start  = (cur_state == IDLE) && start;
        accept_nibble = (cur_state == READ) && in_valid;
        loop_exit     = (cur_state == COMPUTE_4) && advance;
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            IDLE:      if (start) next_state = READ;
            READ:      if (in_valid && idx == 2'd3) next_state = COMPUTE_1;
            COMPUTE_1: if (advance) next_state = COMPUTE_2;
                       else if (timed_out) next_state = DONE;
            COMPUTE_2: if (advance) next_state = COMPUTE_3;
                       else if (timed_out) next_state = DONE;
            COMPUTE_3: if (advance) next_state = COMPUTE_4;
                       else if (timed_out) next_state = DONE;
            COMPUTE_4: if (advance) next_state = (continue_while && !limit_hit) ? COMPUTE_1 : DONE;
                       else if (timed_out) next_state = DONE;
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase

        timer_next = '0;
        if (in_compute && next_state == cur_state) timer_next = timer + 1'b1;

        state    = cur_state;
        busy     = (cur_state != IDLE);
        in_ready = (cur_state == READ);
        load_x   = accept_nibble && (idx == 2'd0);
        load_dx  = accept_nibble && (idx == 2'd1);
        load_a   = accept_nibble && (idx == 2'd2);
        load_u   = accept_nibble && (idx == 2'd3);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur_state <= IDLE;
        else       cur_state <= next_state;
    end

    // Run bookkeeping: operand index, phase timer, iteration count and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            timer      <= '0;
            iter_count <= '0;
            error      <= 1'b0;
            done       <= 1'b0;
        end else begin
            timer <= timer_next;
            done  <= (next_state == DONE);
            if (accept_start) begin
                idx        <= '0;
                iter_count <= '0;
                error      <= 1'b0;
            end
            if (accept_nibble) idx <= idx + 1'b1;
            if (loop_exit) iter_count <= iter_inc;
            if ((loop_exit && limit_hit) || timed_out) error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_diffeq_controller.sv
// Table-driven bench for diffeq_controller: instance a (no practical limit, TIMEOUT=8)
// and instance b (MAX_ITER=2, TIMEOUT=8) share stimulus; sel picks which one is observed and started.
module tb_diffeq_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic compute_done = 1'b0;
    logic continue_while = 1'b0;
    logic sel = 1'b0;

    logic start_a, start_b;
    logic in_ready_a, load_x_a, load_dx_a, load_a_a, load_u_a, busy_a, done_a, error_a;
    logic in_ready_b, load_x_b, load_dx_b, load_a_b, load_u_b, busy_b, done_b, error_b;
    logic [2:0] state_a, state_b;
    logic [7:0] iter_a, iter_b;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    diffeq_controller #(.MAX_ITER(255), .TIMEOUT(8), .ITER_W(8)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid),
        .compute_done(compute_done), .continue_while(continue_while),
        .in_ready(in_ready_a), .load_x(load_x_a), .load_dx(load_dx_a), .load_a(load_a_a),
        .load_u(load_u_a), .state(state_a), .busy(busy_a), .done(done_a), .error(error_a),
        .iter_count(iter_a)
    );

    diffeq_controller #(.MAX_ITER(2), .TIMEOUT(8), .ITER_W(8)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid),
        .compute_done(compute_done), .continue_while(continue_while),
        .in_ready(in_ready_b), .load_x(load_x_b), .load_dx(load_dx_b), .load_a(load_a_b),
        .load_u(load_u_b), .state(state_b), .busy(busy_b), .done(done_b), .error(error_b),
        .iter_count(iter_b)
    );

    logic [18:0] observed;
    assign observed = sel ?
        {state_b, load_u_b, load_a_b, load_dx_b, load_x_b, in_ready_b, busy_b, done_b, error_b, iter_b} :
        {state_a, load_u_a, load_a_a, load_dx_a, load_x_a, in_ready_a, busy_a, done_a, error_a, iter_a};

    typedef struct {
        logic       start;
        logic       in_valid;
        logic       cd;
        logic       cw;
        logic [2:0] st;
        logic [3:0] loads;
        logic       rdy;
        logic       busy;
        logic       dn;
        logic       err;
        logic [7:0] iter;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_row(logic s, logic iv, logic cd, logic cw, logic [2:0] st,
                                    logic [3:0] loads, logic rdy, logic bsy, logic dn,
                                    logic err, logic [7:0] iter);
        vec_t v;
        v.start = s; v.in_valid = iv; v.cd = cd; v.cw = cw;
        v.st = st; v.loads = loads; v.rdy = rdy; v.busy = bsy;
        v.dn = dn; v.err = err; v.iter = iter;
        vecs.push_back(v);
    endfunction

    // n cycles in one compute phase with compute_done raised on the last one.
    function automatic void add_phase(logic [2:0] st, int n, logic cw, logic [7:0] iter, logic err);
        for (int i = 0; i < n; i++)
            add_row(1'b0, 1'b0, (i == n - 1), cw, st, 4'b0000, 1'b0, 1'b1, 1'b0, err, iter);
    endfunction

    function automatic void add_load(logic [7:0] iter, logic err);
        for (int k = 0; k < 4; k++)
            add_row(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 4'(1 << k), 1'b1, 1'b1, 1'b0, err, iter);
    endfunction

    function automatic void add_iteration(int n, logic cw, logic [7:0] iter, logic err);
        add_phase(3'b010, n, cw, iter, err);
        add_phase(3'b011, n, cw, iter, err);
        add_phase(3'b100, n, cw, iter, err);
        add_phase(3'b101, n, cw, iter, err);
    endfunction

    task automatic compare(input string tag, input logic [18:0] act, input logic [18:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got st=%b ld=%b rdy=%b busy=%b done=%b err=%b iter=%0d, want st=%b ld=%b rdy=%b busy=%b done=%b err=%b iter=%0d",
                     tag, act[18:16], act[15:12], act[11], act[10], act[9], act[8], act[7:0],
                     exp[18:16], exp[15:12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        start = v.start;
        in_valid = v.in_valid;
        compute_done = v.cd;
        continue_while = v.cw;
    endtask

    task automatic check_output(input vec_t v, input string tag, input int row);
        compare($sformatf("%s row %0d", tag, row), observed,
                {v.st, v.loads, v.rdy, v.busy, v.dn, v.err, v.iter});
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            apply_stimulus(vecs[i]);
            #1;
            check_output(vecs[i], tag, i);
        end
        vecs.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        compare("reset_a", observed, 19'd0);
        sel = 1'b1;
        #1;
        compare("reset_b", observed, 19'd0);
        sel = 1'b0;
        reset = 1'b0;

        // Normal run: done on 3rd cycle of each phase, continue_while 1,1,0.
        add_row(1, 0, 0, 0, 3'b000, 4'b0000, 0, 0, 0, 0, 8'd0);
        add_load(8'd0, 1'b0);
        add_iteration(3, 1'b1, 8'd0, 1'b0);
        add_iteration(3, 1'b1, 8'd1, 1'b0);
        add_iteration(3, 1'b0, 8'd2, 1'b0);
        add_row(0, 0, 0, 0, 3'b110, 4'b0000, 0, 1, 1, 0, 8'd3);
        add_row(0, 0, 0, 0, 3'b000, 4'b0000, 0, 0, 0, 0, 8'd3);
        run_table("normal");

        // Gapped input, then a stale compute_done on the first cycle of COMPUTE_2.
        add_row(1, 0, 0, 0, 3'b000, 4'b0000, 0, 0, 0, 0, 8'd3);
        add_row(0, 1, 0, 0, 3'b001, 4'b0001, 1, 1, 0, 0, 8'd0);
        add_row(0, 0, 0, 0, 3'b001, 4'b0000, 1, 1, 0, 0, 8'd0);
        add_row(0, 0, 0, 0, 3'b001, 4'b0000, 1, 1, 0, 0, 8'd0);
        add_row(0, 1, 0, 0, 3'b001, 4'b0010, 1, 1, 0, 0, 8'd0);
        add_row(0, 0, 0, 0, 3'b001, 4'b0000, 1, 1, 0, 0, 8'd0);
        add_row(0, 1, 0, 0, 3'b001, 4'b0100, 1, 1, 0, 0, 8'd0);
        add_row(0, 1, 0, 0, 3'b001, 4'b1000, 1, 1, 0, 0, 8'd0);
        add_phase(3'b010, 2, 1'b0, 8'd0, 1'b0);
        add_row(0, 1, 1, 0, 3'b011, 4'b0000, 0, 1, 0, 0, 8'd0);
        add_row(0, 1, 1, 0, 3'b011, 4'b0000, 0, 1, 0, 0, 8'd0);
        add_phase(3'b100, 2, 1'b0, 8'd0, 1'b0);
        add_phase(3'b101, 2, 1'b0, 8'd0, 1'b0);
        add_row(0, 0, 0, 0, 3'b110, 4'b0000, 0, 1, 1, 0, 8'd1);
        add_row(0, 0, 0, 0, 3'b000, 4'b0000, 0, 0, 0, 0, 8'd1);
        run_table("gap_stale");

        // Timeout in COMPUTE_3 after 8 cycles, then a restart clears error.
        add_row(1, 0, 0, 0, 3'b000, 4'b0000, 0, 0, 0, 0, 8'd1);
        add_load(8'd0, 1'b0);
        add_phase(3'b010, 2, 1'b0, 8'd0, 1'b0);
        add_phase(3'b011, 2, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 8; i++)
            add_row(0, 0, 0, 0, 3'b100, 4'b0000, 0, 1, 0, 0, 8'd0);
        add_row(0, 0, 0, 0, 3'b110, 4'b0000, 0, 1, 1, 1, 8'd0);
        add_row(0, 0, 0, 0, 3'b000, 4'b0000, 0, 0, 0, 1, 8'd0);
        add_row(1, 0, 0, 0, 3'b000, 4'b0000, 0, 0, 0, 1, 8'd0);
        add_row(0, 0, 0, 0, 3'b001, 4'b0000, 1, 1, 0, 0, 8'd0);
        add_load(8'd0, 1'b0);
        add_iteration(2, 1'b0, 8'd0, 1'b0);
        add_row(0, 0, 0, 0, 3'b110, 4'b0000, 0, 1, 1, 0, 8'd1);
        add_row(0, 0, 0, 0, 3'b000, 4'b0000, 0, 0, 0, 0, 8'd1);
        run_table("timeout");

        // Iteration limit of 2 with continue_while held high.
        sel = 1'b1;
        add_row(1, 0, 0, 1, 3'b000, 4'b0000, 0, 0, 0, 0, 8'd0);
        add_load(8'd0, 1'b0);
        add_iteration(2, 1'b1, 8'd0, 1'b0);
        add_iteration(2, 1'b1, 8'd1, 1'b0);
        add_row(0, 0, 0, 1, 3'b110, 4'b0000, 0, 1, 1, 1, 8'd2);
        add_row(0, 0, 0, 1, 3'b000, 4'b0000, 0, 0, 0, 1, 8'd2);
        run_table("limit");
        sel = 1'b0;

        // Asynchronous reset in the middle of COMPUTE_2.
        add_row(1, 0, 0, 0, 3'b000, 4'b0000, 0, 0, 0, 0, 8'd1);
        add_load(8'd0, 1'b0);
        add_phase(3'b010, 3, 1'b0, 8'd0, 1'b0);
        add_row(0, 0, 0, 0, 3'b011, 4'b0000, 0, 1, 0, 0, 8'd0);
        run_table("pre_reset");
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        compare("async_reset", observed, 19'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        add_row(0, 0, 0, 0, 3'b000, 4'b0000, 0, 0, 0, 0, 8'd0);
        add_row(0, 0, 0, 0, 3'b000, 4'b0000, 0, 0, 0, 0, 8'd0);
        add_row(1, 0, 0, 0, 3'b000, 4'b0000, 0, 0, 0, 0, 8'd0);
        add_load(8'd0, 1'b0);
        add_iteration(2, 1'b0, 8'd0, 1'b0);
        add_row(0, 0, 0, 0, 3'b110, 4'b0000, 0, 1, 1, 0, 8'd1);
        add_row(0, 0, 0, 0, 3'b000, 4'b0000, 0, 0, 0, 0, 8'd1);
        run_table("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
